shift_register_8bit: RTL and testbench

- Parallel-load / serial-shift register: the data path of the SPI sender.
- The controller loads a byte in parallel. The register then shifts one bit per clock toward the MSB, and the MSB serves as the serial line (MOSI).
- Parallel outputs are always visible for status and debug.
- Clock gating (TE, empty detect) and bit counting live in the enclosing sender, not here.

---
 rtl/spi_pkg.sv | 9 +
 rtl/shift_register_8bit.sv | 47 ++++
 tb/tb_shift_register_8bit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants: word width and SH_LD mode encodings used by the sender and receiver.
package spi_pkg;

  localparam int unsigned SPI_WORD_W = 8;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;

endpackage

// File: rtl/shift_register_8bit.sv
// Parallel-load / serial-shift register forming the SPI sender data path.
// The serial output taps the end of the register that leaves first.
module shift_register_8bit
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH     = SPI_WORD_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] P_DATA_IN,
  input  logic             S_DATA_IN,
  input  logic             SH_LD,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             S_DATA_OUT
);

  if (WIDTH < 2) begin : g_bad_width
    $error("shift_register_8bit: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (SH_LD == MODE_LOAD) begin
      q_d = P_DATA_IN;
    end else if (MSB_FIRST) begin
      q_d = {q_q[WIDTH-2:0], S_DATA_IN};
    end else begin
      q_d = {S_DATA_IN, q_q[WIDTH-1:1]};
    end
  end

  // Clear has priority over both load and shift.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign DATA_OUT   = q_q;
  assign S_DATA_OUT = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_shift_register_8bit.sv
// Scoreboard bench: driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_shift_register_8bit;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 8-bit MSB-first instance
  logic       clr8 = 1'b0, shld8 = 1'b0, sin8 = 1'b0;
  logic [7:0] pin8 = '0;
  logic [7:0] dout8;
  logic       sout8;

  // 4-bit LSB-first instance
  logic       clr4 = 1'b0, shld4 = 1'b0, sin4 = 1'b0;
  logic [3:0] pin4 = '0;
  logic [3:0] dout4;
  logic       sout4;

  shift_register_8bit #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
    .CLK       (CLK),
    .CLR       (clr8),
    .P_DATA_IN (pin8),
    .S_DATA_IN (sin8),
    .SH_LD     (shld8),
    .DATA_OUT  (dout8),
    .S_DATA_OUT(sout8)
  );

  shift_register_8bit #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut4 (
    .CLK       (CLK),
    .CLR       (clr4),
    .P_DATA_IN (pin4),
    .S_DATA_IN (sin4),
    .SH_LD     (shld4),
    .DATA_OUT  (dout4),
    .S_DATA_OUT(sout4)
  );

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  int         exp_dut_q[$];
  int         exp_tag_q[$];
  logic [7:0] exp_data_q[$];
  logic       exp_sout_q[$];

  task automatic push_exp(input int dut, input logic [7:0] d, input logic s);
    exp_dut_q.push_back(dut);
    exp_tag_q.push_back(step_no);
    exp_data_q.push_back(d);
    exp_sout_q.push_back(s);
  endtask

  task automatic step8(input logic clr, input logic shld, input logic [7:0] p, input logic s,
                       input logic [7:0] exp_d, input logic exp_s);
    clr8 = clr; shld8 = shld; pin8 = p; sin8 = s;
    @(posedge CLK);
    step_no++;
    push_exp(8, exp_d, exp_s);
    #1;
  endtask

  task automatic step4(input logic clr, input logic shld, input logic [3:0] p, input logic s,
                       input logic [3:0] exp_d, input logic exp_s);
    clr4 = clr; shld4 = shld; pin4 = p; sin4 = s;
    @(posedge CLK);
    step_no++;
    push_exp(4, {4'h0, exp_d}, exp_s);
    #1;
  endtask

  // Monitor: outputs are registered, so every edge presents a new result
  initial begin
    int         dut, tag;
    logic [7:0] ed, ad;
    logic       es, as;
    forever begin
      @(negedge CLK);
      if (exp_dut_q.size() > 0) begin
        dut = exp_dut_q.pop_front();
        tag = exp_tag_q.pop_front();
        ed  = exp_data_q.pop_front();
        es  = exp_sout_q.pop_front();
        ad  = (dut == 8) ? dout8 : {4'h0, dout4};
        as  = (dut == 8) ? sout8 : sout4;
        checks++;
        if (ad !== ed) begin
          errors++;
          $display("FAIL data_out w%0d step %0d: got %h expected %h", dut, tag, ad, ed);
        end
        checks++;
        if (as !== es) begin
          errors++;
          $display("FAIL s_data_out w%0d step %0d: got %b expected %b", dut, tag, as, es);
        end
      end
    end
  end

  initial begin
    logic [7:0] fill_bits;
    logic [7:0] shift_exp [8];
    logic [7:0] fill_exp  [8];
    int         guard;

    shift_exp = '{8'h68, 8'hD0, 8'hA0, 8'h40, 8'h80, 8'h00, 8'h00, 8'h00};
    fill_exp  = '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h19, 8'h32, 8'h65, 8'hCA};
    fill_bits = 8'b1100_1010;  // applied MSB of this constant first

    // Initial reset
    step8(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset beats shift, then reset beats load
    step8(1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b1);
    step8(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    step8(1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b1);
    step8(1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);

    // Load, and reload while held in load mode
    step8(1'b1, 1'b0, 8'hB4, 1'b0, 8'hB4, 1'b1);
    step8(1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0);

    // MSB-first shift-out of B4
    step8(1'b1, 1'b0, 8'hB4, 1'b0, 8'hB4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, 1'b1, 8'hFF, 1'b0, shift_exp[i], shift_exp[i][7]);
    end

    // Serial fill from zero
    step8(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, 1'b1, 8'h00, fill_bits[7-i], fill_exp[i], fill_exp[i][7]);
    end

    // Load interrupts a shift, then reset interrupts a shift
    step8(1'b1, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1);
    step8(1'b1, 1'b1, 8'h00, 1'b0, 8'hFE, 1'b1);
    step8(1'b1, 1'b1, 8'h00, 1'b0, 8'hFC, 1'b1);
    step8(1'b1, 1'b1, 8'h00, 1'b0, 8'hF8, 1'b1);
    step8(1'b1, 1'b0, 8'h81, 1'b0, 8'h81, 1'b1);
    step8(1'b1, 1'b1, 8'h00, 1'b0, 8'h02, 1'b0);
    step8(1'b1, 1'b1, 8'h00, 1'b0, 8'h04, 1'b0);
    step8(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    // Shifting resumes from zero after reset
    step8(1'b1, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0);
    step8(1'b1, 1'b1, 8'h00, 1'b0, 8'h02, 1'b0);

    // 4-bit LSB-first instance
    step4(1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
    step4(1'b1, 1'b0, 4'b1001, 1'b0, 4'b1001, 1'b1);
    step4(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0);
    step4(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0010, 1'b0);
    step4(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0001, 1'b1);
    step4(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
    // Serial-in enters at the top for LSB-first
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 4'b1000, 1'b0);

    guard = 0;
    while (exp_dut_q.size() > 0 && guard < 20) begin
      @(posedge CLK);
      guard++;
    end
    checks++;
    if (exp_dut_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_dut_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
